// File: rtl/rtc_bcd_clock.sv
// rtl/rtc_bcd_clock.sv - 24-hour BCD real-time clock with seconds prescaler, 12/24h display, validated load and daily alarm
module rtc_bcd_clock #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        mode12,
  input  logic        load,
  input  logic [23:0] set_time,
  input  logic        alarm_en,
  input  logic [15:0] alarm_time,
  output logic [3:0]  ms_hr,
  output logic [3:0]  ls_hr,
  output logic [3:0]  ms_min,
  output logic [3:0]  ls_min,
  output logic [3:0]  ms_sec,
  output logic [3:0]  ls_sec,
  output logic        pm,
  output logic        sec_tick,
  output logic        alarm,
  output logic        load_err
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [3:0] h_t, h_u, m_t, m_u, s_t, s_u;
  logic [3:0] n_ht, n_hu, n_mt, n_mu, n_st, n_su;
  logic       tick, set_ok;
  logic [4:0] hr_bin;
  logic [3:0] h12;

  assign tick = en && (cnt == CNT_MAX);

  assign set_ok = (set_time[3:0]   <= 4'd9) && (set_time[7:4]   <= 4'd5) &&
                  (set_time[11:8]  <= 4'd9) && (set_time[15:12] <= 4'd5) &&
                  (set_time[19:16] <= 4'd9) && (set_time[23:20] <= 4'd2) &&
                  !((set_time[23:20] == 4'd2) && (set_time[19:16] > 4'd3));

  // One-second increment: each digit only moves when every lower digit wraps.
  always_comb begin
    n_ht = h_t; n_hu = h_u; n_mt = m_t; n_mu = m_u; n_st = s_t; n_su = s_u;
    if (s_u != 4'd9) n_su = s_u + 4'd1;
    else begin
      n_su = 4'd0;
      if (s_t != 4'd5) n_st = s_t + 4'd1;
      else begin
        n_st = 4'd0;
        if (m_u != 4'd9) n_mu = m_u + 4'd1;
        else begin
          n_mu = 4'd0;
          if (m_t != 4'd5) n_mt = m_t + 4'd1;
          else begin
            n_mt = 4'd0;
            if (h_t == 4'd2 && h_u == 4'd3) begin
              n_ht = 4'd0; n_hu = 4'd0;
            end else if (h_u == 4'd9) begin
              n_ht = h_t + 4'd1; n_hu = 4'd0;
            end else begin
              n_hu = h_u + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      h_t <= 4'd0; h_u <= 4'd0; m_t <= 4'd0; m_u <= 4'd0; s_t <= 4'd0; s_u <= 4'd0;
      sec_tick <= 1'b0;
      alarm    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      alarm    <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (set_ok) begin
          {h_t, h_u, m_t, m_u, s_t, s_u} <= set_time;
          cnt <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (tick) begin
        cnt <= '0;
        {h_t, h_u, m_t, m_u, s_t, s_u} <= {n_ht, n_hu, n_mt, n_mu, n_st, n_su};
        sec_tick <= 1'b1;
        alarm <= alarm_en && ({n_ht, n_hu, n_mt, n_mu} == alarm_time) &&
                 (n_st == 4'd0) && (n_su == 4'd0);
      end else if (en) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign hr_bin = 5'({1'b0, h_t} * 5'd10) + {1'b0, h_u};
  assign h12    = 4'(hr_bin - 5'd12);
  assign pm     = (hr_bin >= 5'd12);

  always_comb begin
    ms_hr = h_t;
    ls_hr = h_u;
    if (mode12) begin
      if (hr_bin == 5'd0) begin
        ms_hr = 4'd1; ls_hr = 4'd2;
      end else if (hr_bin > 5'd12) begin
        if (h12 >= 4'd10) begin
          ms_hr = 4'd1; ls_hr = h12 - 4'd10;
        end else begin
          ms_hr = 4'd0; ls_hr = h12;
        end
      end
    end
  end

  assign ms_min = m_t;
  assign ls_min = m_u;
  assign ms_sec = s_t;
  assign ls_sec = s_u;

endmodule

// File: tb/tb_rtc_bcd_clock.sv
// tb/tb_rtc_bcd_clock.sv - directed plus randomized bench for rtc_bcd_clock against a seconds-of-day model
module tb_rtc_bcd_clock;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, mode12 = 1'b0, load = 1'b0, alarm_en = 1'b0;
  logic [23:0] set_time = '0;
  logic [15:0] alarm_time = '0;
  logic [3:0]  ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec;
  logic        pm, sec_tick, alarm, load_err;

  int vectors = 0;
  int miscompares = 0;

  // Model state: time as seconds since midnight plus prescaler phase.
  int m_sec = 0, m_cnt = 0;
  bit m_tick = 0, m_alarm = 0, m_err = 0;

  rtc_bcd_clock #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode12(mode12), .load(load),
    .set_time(set_time), .alarm_en(alarm_en), .alarm_time(alarm_time),
    .ms_hr(ms_hr), .ls_hr(ls_hr), .ms_min(ms_min), .ls_min(ls_min),
    .ms_sec(ms_sec), .ls_sec(ls_sec), .pm(pm), .sec_tick(sec_tick),
    .alarm(alarm), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int s);
    int hh, mm, ss;
    hh = s / 3600; mm = (s / 60) % 60; ss = s % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic bit is_valid(input logic [23:0] v);
    int hh;
    if (v[3:0] > 9 || v[11:8] > 9 || v[19:16] > 9) return 0;
    if (v[7:4] > 5 || v[15:12] > 5) return 0;
    hh = int'(v[23:20]) * 10 + int'(v[19:16]);
    return hh < 24;
  endfunction

  function automatic int to_sec(input logic [23:0] v);
    return (int'(v[23:20]) * 10 + int'(v[19:16])) * 3600 +
           (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 +
           int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int h, dh;
    logic [23:0] b;
    h = m_sec / 3600;
    dh = h;
    if (mode12) dh = (h == 0) ? 12 : (h > 12 ? h - 12 : h);
    b = to_bcd(m_sec);
    chk({tag, ".hr"}, {24'd0, ms_hr, ls_hr}, {24'd0, 4'(dh / 10), 4'(dh % 10)});
    chk({tag, ".minsec"}, {16'd0, ms_min, ls_min, ms_sec, ls_sec}, {16'd0, b[15:0]});
    chk({tag, ".flags"}, {28'd0, pm, sec_tick, alarm, load_err},
        {28'd0, 1'(h >= 12), m_tick, m_alarm, m_err});
  endtask

  task automatic model_edge();
    logic [23:0] b;
    m_tick = 0; m_alarm = 0; m_err = 0;
    if (load) begin
      if (is_valid(set_time)) begin
        m_sec = to_sec(set_time);
        m_cnt = 0;
      end else begin
        m_err = 1;
      end
    end else if (en) begin
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_sec = (m_sec + 1) % 86400;
        m_tick = 1;
        b = to_bcd(m_sec);
        m_alarm = alarm_en && (b[23:8] == alarm_time) && (b[7:0] == 8'h00);
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_load(input logic [23:0] t, input string tag);
    set_time = t;
    load = 1'b1;
    step(tag);
    load = 1'b0;
  endtask

  initial begin
    logic [23:0] nb;
    #2;
    check_all("reset0");
    #1 rst = 1'b1;

    // Run to 00:00:05, then reset between edges.
    en = 1'b1;
    repeat (20) step("run5");
    chk("at_000005", {8'd0, ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec}, 32'h000005);
    @(negedge clk);
    rst = 1'b0;
    m_sec = 0; m_cnt = 0; m_tick = 0; m_alarm = 0; m_err = 0;
    #1 check_all("async_rst");
    #2 rst = 1'b1;
    repeat (8) step("post_rst");

    // Midnight wrap with TICK_DIV=4.
    do_load(24'h235958, "load_wrap");
    repeat (4) step("wrap_a");
    chk("at_235959", {8'd0, ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec}, 32'h235959);
    repeat (4) step("wrap_b");
    chk("at_000000", {8'd0, ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec}, 32'h000000);

    // 12-hour display.
    en = 1'b0;
    mode12 = 1'b1;
    do_load(24'h003000, "m12_0030");
    do_load(24'h120000, "m12_1200");
    do_load(24'h130500, "m12_1305");
    chk("m12_1305_hr", {24'd0, ms_hr, ls_hr, 3'd0, pm}, {24'd0, 8'h01, 4'd1});
    mode12 = 1'b0;
    #1 check_all("m24_1305");

    // Invalid loads leave time untouched.
    do_load(24'h240000, "bad_hr");
    do_load(24'h096000, "bad_min");
    do_load(24'h09005A, "bad_sec");
    step("bad_clear");

    // Alarm fires with sec_tick at 07:00:00, only when enabled.
    en = 1'b1;
    alarm_time = 16'h0700;
    alarm_en = 1'b1;
    do_load(24'h065959, "al_load");
    repeat (4) step("al_on");
    chk("alarm_fired", {30'd0, alarm, sec_tick}, 32'd3);
    alarm_en = 1'b0;
    do_load(24'h065959, "al_load2");
    repeat (4) step("al_off");

    // Hold and load-over-tick priority.
    en = 1'b0;
    repeat (20) step("hold");
    en = 1'b1;
    repeat (3) step("pre_tick");
    do_load(24'h101010, "load_on_tick");
    chk("no_tick_on_load", {31'd0, sec_tick}, 32'd0);
    repeat (4) step("after_prio");

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom % 8) != 0;
      if ($urandom % 50 == 0) mode12 = ~mode12;
      alarm_en = ($urandom % 4) != 0;
      if ($urandom % 40 == 0) begin
        nb = to_bcd(((m_sec / 60 + 1) * 60) % 86400);
        alarm_time = nb[23:8];
      end
      if ($urandom % 16 == 0) begin
        if ($urandom % 4 != 0)
          set_time = to_bcd((($urandom % 1440) * 60 + 55 + ($urandom % 5)) % 86400);
        else
          set_time = 24'($urandom);
        load = 1'b1;
      end
      step("rand");
      load = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
